// File: rtl/allocator_pkg.sv
// allocator_pkg
// Shared types and constants for the allocator datapath. The header LSU and
// the core agree on these request/response layouts.
//   DATA_W             : machine word width (addresses and header fields)
//   LOCK_ADDR_DEFAULT  : byte address of the allocator lock word
//   header_data_t      : {addr, size, next_addr} of one free-list node
//   req_lsu_op_e       : operation requested from the header LSU
//   header_data_req_t  : core -> LSU request {header_data, lsu_op, val}
//   header_data_rsp_t  : LSU -> core response {header_data, val}
package allocator_pkg;

  localparam int DATA_W = 64;

  localparam logic [DATA_W-1:0] LOCK_ADDR_DEFAULT = '0;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] size;
    logic [DATA_W-1:0] next_addr;
  } header_data_t;

  // Encodings 5..7 are undefined and answered with an empty response.
  typedef enum logic [2:0] {
    LOCK   = 3'd0,
    UNLOCK = 3'd1,
    LOAD   = 3'd2,
    INSERT = 3'd3,
    DELETE = 3'd4
  } req_lsu_op_e;

  typedef struct packed {
    header_data_t header_data;
    req_lsu_op_e  lsu_op;
    logic         val;
  } header_data_req_t;

  typedef struct packed {
    header_data_t header_data;
    logic         val;
  } header_data_rsp_t;

endpackage

// File: rtl/header_lsu.sv
// header_lsu
// Load/store unit that moves free-list node headers between the allocator
// core and memory, and implements the allocator's spin lock. One request is
// in flight at a time; each produces a single one-cycle response pulse.
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   req_from_core_i     : request {header_data, lsu_op, val}
//   lsu_ready_o         : high only when idle and able to accept a request
//   rsp_to_core_o       : response {header_data, val}, val pulses once
//   mem_req_o/mem_we_o  : memory request / write enable, held until mem_gnt_i
//   mem_addr_o          : byte address of the access
//   mem_wdata_o         : write data
//   mem_gnt_i           : access granted (a write completes here)
//   mem_rvalid_i        : read data valid, earliest one cycle after grant
//   mem_rdata_i         : read data
module header_lsu
  import allocator_pkg::*;
#(
  parameter logic [DATA_W-1:0] LOCK_ADDR   = LOCK_ADDR_DEFAULT,
  parameter logic [DATA_W-1:0] NEXT_OFFSET = DATA_W'(DATA_W / 8)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  header_data_req_t  req_from_core_i,
  output logic              lsu_ready_o,
  output header_data_rsp_t  rsp_to_core_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [3:0] {
    IDLE,
    RD_SIZE,
    RD_NEXT,
    WR_SIZE,
    WR_NEXT,
    LOCK_RD,
    LOCK_WR,
    UNLOCK_WR,
    RSP
  } state_e;

  typedef struct packed {
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  state_e            state_q;
  logic              pending_q;
  logic              ready_q;
  header_data_t      hdr_q;
  logic [DATA_W-1:0] size_q;
  header_data_rsp_t  rsp_q;
  mem_cmd_t          mem_q;

  logic [DATA_W-1:0] next_addr_req;
  logic [DATA_W-1:0] next_addr_hdr;
  logic              rd_granted;
  logic              access_done;

  function automatic mem_cmd_t issue(input logic              we,
                                     input logic [DATA_W-1:0] addr,
                                     input logic [DATA_W-1:0] wdata);
    return '{req: 1'b1, we: we, addr: addr, wdata: wdata};
  endfunction

  // Address of the next_addr field, for the incoming request (DELETE goes
  // straight there) and for the latched header. Plain unsigned addition, so
  // it wraps around the top of the address space.
  assign next_addr_req = req_from_core_i.header_data.addr + NEXT_OFFSET;
  assign next_addr_hdr = hdr_q.addr + NEXT_OFFSET;

  // A read is granted while its request is still up; from then on the state
  // waits in "pending" for rvalid. rvalid is only honoured while pending, so
  // stray or late rvalids (including ones from before a reset) are dropped.
  assign rd_granted  = mem_q.req && !mem_q.we && mem_gnt_i && !pending_q;
  assign access_done = (mem_q.req && mem_q.we && mem_gnt_i) ||
                       (pending_q && mem_rvalid_i);

  assign lsu_ready_o   = ready_q;
  assign rsp_to_core_o = rsp_q;
  assign mem_req_o     = mem_q.req;
  assign mem_we_o      = mem_q.we;
  assign mem_addr_o    = mem_q.addr;
  assign mem_wdata_o   = mem_q.wdata;

  // Main FSM. All outputs are registered here: the memory command is loaded
  // on the transition into each memory state and held until the grant, and
  // the response is loaded on the transition into RSP so it is visible for
  // exactly the one cycle spent in RSP. Ready is raised on the way back to
  // IDLE, so it reappears the cycle after the response pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      ready_q   <= 1'b0;
      hdr_q     <= '0;
      size_q    <= '0;
      rsp_q     <= '0;
      mem_q     <= '0;
    end else begin
      rsp_q.val <= 1'b0;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (ready_q && req_from_core_i.val) begin
            ready_q   <= 1'b0;
            pending_q <= 1'b0;
            hdr_q     <= req_from_core_i.header_data;
            case (req_from_core_i.lsu_op)
              LOCK: begin
                state_q <= LOCK_RD;
                mem_q   <= issue(1'b0, LOCK_ADDR, '0);
              end
              UNLOCK: begin
                state_q <= UNLOCK_WR;
                mem_q   <= issue(1'b1, LOCK_ADDR, '0);
              end
              LOAD: begin
                state_q <= RD_SIZE;
                mem_q   <= issue(1'b0, req_from_core_i.header_data.addr, '0);
              end
              INSERT: begin
                state_q <= WR_SIZE;
                mem_q   <= issue(1'b1, req_from_core_i.header_data.addr,
                                 req_from_core_i.header_data.size);
              end
              DELETE: begin
                state_q <= WR_NEXT;
                mem_q   <= issue(1'b1, next_addr_req,
                                 req_from_core_i.header_data.next_addr);
              end
              default: begin
                state_q           <= RSP;
                rsp_q.header_data <= '0;
                rsp_q.val         <= 1'b1;
              end
            endcase
          end
        end

        RD_SIZE, RD_NEXT, WR_SIZE, WR_NEXT, LOCK_RD, LOCK_WR, UNLOCK_WR: begin
          if (rd_granted) begin
            mem_q.req <= 1'b0;
            pending_q <= 1'b1;
          end
          if (access_done) begin
            pending_q <= 1'b0;
            case (state_q)
              RD_SIZE: begin
                size_q  <= mem_rdata_i;
                state_q <= RD_NEXT;
                mem_q   <= issue(1'b0, next_addr_hdr, '0);
              end
              RD_NEXT: begin
                state_q                     <= RSP;
                mem_q                       <= '0;
                rsp_q.header_data.addr      <= hdr_q.addr;
                rsp_q.header_data.size      <= size_q;
                rsp_q.header_data.next_addr <= mem_rdata_i;
                rsp_q.val                   <= 1'b1;
              end
              WR_SIZE: begin
                state_q <= WR_NEXT;
                mem_q   <= issue(1'b1, next_addr_hdr, hdr_q.next_addr);
              end
              WR_NEXT: begin
                state_q           <= RSP;
                mem_q             <= '0;
                rsp_q.header_data <= hdr_q;
                rsp_q.val         <= 1'b1;
              end
              LOCK_RD: begin
                // Lock held by someone else: spin by re-reading immediately.
                if (mem_rdata_i != '0) begin
                  mem_q <= issue(1'b0, LOCK_ADDR, '0);
                end else begin
                  state_q <= LOCK_WR;
                  mem_q   <= issue(1'b1, LOCK_ADDR, DATA_W'(1));
                end
              end
              LOCK_WR, UNLOCK_WR: begin
                state_q           <= RSP;
                mem_q             <= '0;
                rsp_q.header_data <= '0;
                rsp_q.val         <= 1'b1;
              end
              default: begin
                state_q <= IDLE;
              end
            endcase
          end
        end

        RSP: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_header_lsu.sv
// tb_header_lsu
// Directed bench for header_lsu: a vector table of single operations against
// a behavioural memory with configurable grant/rvalid delays, followed by
// hand-written sequences for reset, ignored requests and reset mid-spin.
module tb_header_lsu;
  import allocator_pkg::*;

  localparam logic [63:0] LOCK_A = 64'h0;

  logic              clk;
  logic              rst;
  header_data_req_t  req_from_core;
  logic              lsu_ready;
  header_data_rsp_t  rsp_to_core;
  logic              mem_req;
  logic              mem_we;
  logic [63:0]       mem_addr;
  logic [63:0]       mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [63:0]       mem_rdata;

  header_lsu dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_from_core_i(req_from_core),
    .lsu_ready_o    (lsu_ready),
    .rsp_to_core_o  (rsp_to_core),
    .mem_req_o      (mem_req),
    .mem_we_o       (mem_we),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_gnt_i      (mem_gnt),
    .mem_rvalid_i   (mem_rvalid),
    .mem_rdata_i    (mem_rdata)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } acc_t;

  typedef struct {
    logic [2:0]   op;
    header_data_t hdr;
    int           gnt_dly;
    int           rv_dly;
    int           lock_busy;
    header_data_t exp_rsp;
    int           exp_acc;
    logic [63:0]  exp_first_addr;
    logic         exp_last_we;
    logic [63:0]  exp_last_addr;
    logic [63:0]  exp_last_wdata;
    int           exp_lat;
  } vec_t;

  // Memory model configuration, written only by the stimulus process.
  int gnt_dly   = 0;
  int rv_dly    = 1;
  int lock_busy = 0;
  int cfg_gen   = 0;

  // Written only by the memory model / response monitor.
  acc_t        acc_log[$];
  logic [63:0] mem_model[logic [63:0]];
  int          stable_err = 0;
  int          rsp_count  = 0;

  int n_cmp  = 0;
  int n_fail = 0;

  // Per-operation observations filled by applyStimulus.
  int           log_start;
  int           rsp_start;
  int           stable_start;
  int           lat;
  int           glitch;
  logic         timed_out;
  logic         ready_after;
  header_data_t got;

  // Memory model: grants after gnt_dly stall cycles, returns read data
  // rv_dly cycles after the grant, and reports lock_busy reads of the lock
  // word as "held" before falling back to the stored value. It keeps serving
  // an outstanding read across a DUT reset so a late rvalid can be seen.
  initial begin : mem_slave
    int          stall_cnt   = 0;
    int          rd_cnt      = 0;
    logic        rd_pending  = 1'b0;
    logic [63:0] rd_data     = '0;
    int          seen_gen    = 0;
    int          lock_served = 0;
    logic        snap_we     = 1'b0;
    logic [63:0] snap_addr   = '0;
    logic [63:0] snap_wdata  = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    mem_model[64'h10] = 64'h100;
    mem_model[64'h18] = 64'h40;
    forever begin
      @(negedge clk);
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (cfg_gen != seen_gen) begin
        seen_gen    = cfg_gen;
        lock_served = 0;
      end
      if (rd_pending) begin
        if (rd_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rd_data;
          rd_pending = 1'b0;
        end else begin
          rd_cnt--;
        end
      end
      if (mem_req === 1'b1) begin
        if (stall_cnt > 0 && (mem_we !== snap_we || mem_addr !== snap_addr ||
                              mem_wdata !== snap_wdata)) begin
          stable_err++;
        end
        if (stall_cnt == 0) begin
          snap_we    = mem_we;
          snap_addr  = mem_addr;
          snap_wdata = mem_wdata;
        end
        if (stall_cnt < gnt_dly) begin
          stall_cnt++;
        end else begin
          mem_gnt   = 1'b1;
          stall_cnt = 0;
          acc_log.push_back('{we: mem_we, addr: mem_addr,
                              wdata: (mem_we ? mem_wdata : 64'h0)});
          if (mem_we) begin
            mem_model[mem_addr] = mem_wdata;
          end else begin
            if (mem_addr == LOCK_A && lock_served < lock_busy) begin
              rd_data = 64'h1;
              lock_served++;
            end else begin
              rd_data = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 64'h0;
            end
            rd_pending = 1'b1;
            rd_cnt     = rv_dly - 1;
          end
        end
      end else begin
        stall_cnt = 0;
      end
    end
  end

  // Counts response pulses, sampled 1 ns after each rising edge.
  initial begin : rsp_monitor
    forever begin
      @(posedge clk);
      #1;
      if (rsp_to_core.val === 1'b1) rsp_count++;
    end
  end

  function automatic header_data_t hd(input logic [63:0] a, input logic [63:0] s,
                                      input logic [63:0] n);
    return '{addr: a, size: s, next_addr: n};
  endfunction

  function automatic vec_t mkVec(input logic [2:0] op, input header_data_t hdr,
                                 input int gd, input int rd, input int lb,
                                 input header_data_t exp, input int acc,
                                 input logic [63:0] first_a, input logic lwe,
                                 input logic [63:0] la, input logic [63:0] lwd,
                                 input int elat);
    vec_t v;
    v.op = op; v.hdr = hdr; v.gnt_dly = gd; v.rv_dly = rd; v.lock_busy = lb;
    v.exp_rsp = exp; v.exp_acc = acc; v.exp_first_addr = first_a;
    v.exp_last_we = lwe; v.exp_last_addr = la; v.exp_last_wdata = lwd;
    v.exp_lat = elat;
    return v;
  endfunction

  task automatic compareValue(input string name, input logic [191:0] act,
                              input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic configMem(input int gd, input int rd, input int lb);
    gnt_dly   = gd;
    rv_dly    = rd;
    lock_busy = lb;
    cfg_gen++;
  endtask

  task automatic waitReady();
    int n = 0;
    while (lsu_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    compareValue("ready_before_req", 192'(lsu_ready), 192'(1));
  endtask

  // Issues one request, waits (bounded) for its response and records what
  // was seen; the operation's accesses land in acc_log from log_start on.
  task automatic applyStimulus(input vec_t v);
    configMem(v.gnt_dly, v.rv_dly, v.lock_busy);
    log_start    = acc_log.size();
    rsp_start    = rsp_count;
    stable_start = stable_err;
    glitch       = 0;
    waitReady();
    req_from_core.header_data = v.hdr;
    req_from_core.lsu_op      = req_lsu_op_e'(v.op);
    req_from_core.val         = 1'b1;
    @(negedge clk);
    req_from_core.val = 1'b0;
    lat = 1;
    while (rsp_to_core.val !== 1'b1 && lat < 300) begin
      if (lsu_ready === 1'b1) glitch++;
      @(negedge clk);
      lat++;
    end
    timed_out = (rsp_to_core.val !== 1'b1);
    got       = rsp_to_core.header_data;
    @(negedge clk);
    ready_after = lsu_ready;
    repeat (2) @(negedge clk);
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    int   n_acc;
    acc_t first_a;
    acc_t last_a;
    string tag;
    tag   = $sformatf("vec%0d", idx);
    n_acc = acc_log.size() - log_start;
    compareValue({tag, "_timeout"}, 192'(timed_out), 192'(0));
    compareValue({tag, "_rsp_data"}, got, v.exp_rsp);
    compareValue({tag, "_rsp_pulses"}, 192'(rsp_count - rsp_start), 192'(1));
    compareValue({tag, "_acc_count"}, 192'(n_acc), 192'(v.exp_acc));
    compareValue({tag, "_ready_busy"}, 192'(glitch), 192'(0));
    compareValue({tag, "_ready_after"}, 192'(ready_after), 192'(1));
    compareValue({tag, "_mem_stable"}, 192'(stable_err - stable_start), 192'(0));
    if (n_acc > 0 && v.exp_acc > 0) begin
      first_a = acc_log[log_start];
      last_a  = acc_log[acc_log.size() - 1];
      compareValue({tag, "_first_addr"}, 192'(first_a.addr), 192'(v.exp_first_addr));
      compareValue({tag, "_last_we"}, 192'(last_a.we), 192'(v.exp_last_we));
      compareValue({tag, "_last_addr"}, 192'(last_a.addr), 192'(v.exp_last_addr));
      compareValue({tag, "_last_wdata"}, 192'(last_a.wdata), 192'(v.exp_last_wdata));
    end
    if (v.exp_lat != 0) begin
      compareValue({tag, "_latency"}, 192'(lat), 192'(v.exp_lat));
    end
  endtask

  vec_t vecs[14];

  initial begin : stimulus
    int n_wr;
    int rsp_before;
    header_data_t zero_h;
    zero_h = '0;

    // Expected values assume DATA_W=64, NEXT_OFFSET=8, LOCK_ADDR=0 and the
    // memory preloaded with [0x10]=0x100, [0x18]=0x40.
    vecs[0]  = mkVec(LOAD,   hd(64'h10, 0, 0), 0, 1, 0, hd(64'h10, 64'h100, 64'h40),
                     2, 64'h10, 1'b0, 64'h18, 64'h0, 0);
    vecs[1]  = mkVec(INSERT, hd(64'h90, 64'hC0, 64'h40), 1, 1, 0, hd(64'h90, 64'hC0, 64'h40),
                     2, 64'h90, 1'b1, 64'h98, 64'h40, 0);
    vecs[2]  = mkVec(LOAD,   hd(64'h90, 0, 0), 0, 2, 0, hd(64'h90, 64'hC0, 64'h40),
                     2, 64'h90, 1'b0, 64'h98, 64'h0, 0);
    vecs[3]  = mkVec(DELETE, hd(64'h10, 64'h55, 64'h90), 0, 1, 0, hd(64'h10, 64'h55, 64'h90),
                     1, 64'h18, 1'b1, 64'h18, 64'h90, 0);
    vecs[4]  = mkVec(LOAD,   hd(64'h10, 0, 0), 0, 1, 0, hd(64'h10, 64'h100, 64'h90),
                     2, 64'h10, 1'b0, 64'h18, 64'h0, 0);
    vecs[5]  = mkVec(UNLOCK, hd(64'h1, 64'h2, 64'h3), 0, 1, 0, zero_h,
                     1, 64'h0, 1'b1, 64'h0, 64'h0, 0);
    vecs[6]  = mkVec(LOCK,   hd(64'h5, 64'h6, 64'h7), 0, 1, 0, zero_h,
                     2, 64'h0, 1'b1, 64'h0, 64'h1, 0);
    vecs[7]  = mkVec(UNLOCK, hd(64'h0, 64'h0, 64'h0), 2, 1, 0, zero_h,
                     1, 64'h0, 1'b1, 64'h0, 64'h0, 0);
    vecs[8]  = mkVec(LOCK,   hd(64'h0, 64'h0, 64'h0), 0, 1, 3, zero_h,
                     5, 64'h0, 1'b1, 64'h0, 64'h1, 0);
    vecs[9]  = mkVec(3'd6,   hd(64'hAA, 64'hBB, 64'hCC), 0, 1, 0, zero_h,
                     0, 64'h0, 1'b0, 64'h0, 64'h0, 1);
    vecs[10] = mkVec(INSERT, hd(64'hFFFF_FFFF_FFFF_FFFC, 64'h7, 64'h33), 0, 1, 0,
                     hd(64'hFFFF_FFFF_FFFF_FFFC, 64'h7, 64'h33),
                     2, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 64'h4, 64'h33, 0);
    vecs[11] = mkVec(LOAD,   hd(64'hFFFF_FFFF_FFFF_FFFC, 0, 0), 0, 1, 0,
                     hd(64'hFFFF_FFFF_FFFF_FFFC, 64'h7, 64'h33),
                     2, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h4, 64'h0, 0);
    vecs[12] = mkVec(LOAD,   hd(64'h10, 0, 0), 5, 3, 0, hd(64'h10, 64'h100, 64'h90),
                     2, 64'h10, 1'b0, 64'h18, 64'h0, 0);
    vecs[13] = mkVec(3'd7,   hd(64'h1, 64'h1, 64'h1), 0, 1, 0, zero_h,
                     0, 64'h0, 1'b0, 64'h0, 64'h0, 1);

    // Reset state: everything quiet while reset is held, ready right after.
    rst           = 1'b1;
    req_from_core = '0;
    repeat (3) @(negedge clk);
    compareValue("reset_ready", 192'(lsu_ready), 192'(0));
    compareValue("reset_mem_req", 192'(mem_req), 192'(0));
    compareValue("reset_mem_we", 192'(mem_we), 192'(0));
    compareValue("reset_mem_addr", 192'(mem_addr), 192'(0));
    compareValue("reset_mem_wdata", 192'(mem_wdata), 192'(0));
    compareValue("reset_rsp_val", 192'(rsp_to_core.val), 192'(0));
    compareValue("reset_rsp_data", rsp_to_core.header_data, 192'(0));
    rst = 1'b0;
    @(negedge clk);
    compareValue("ready_after_reset", 192'(lsu_ready), 192'(1));

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    // A request presented while busy is dropped, not queued.
    $display("[TB] sequence: request while busy");
    configMem(3, 1, 0);
    log_start = acc_log.size();
    rsp_start = rsp_count;
    waitReady();
    req_from_core.header_data = hd(64'h10, 0, 0);
    req_from_core.lsu_op      = LOAD;
    req_from_core.val         = 1'b1;
    @(negedge clk);
    req_from_core.header_data = hd(64'h200, 64'h1, 64'h2);
    req_from_core.lsu_op      = INSERT;
    repeat (3) @(negedge clk);
    req_from_core.val = 1'b0;
    lat = 0;
    while (rsp_to_core.val !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    compareValue("busy_rsp_seen", 192'(rsp_to_core.val), 192'(1));
    compareValue("busy_rsp_data", rsp_to_core.header_data, hd(64'h10, 64'h100, 64'h90));
    repeat (6) @(negedge clk);
    compareValue("busy_rsp_pulses", 192'(rsp_count - rsp_start), 192'(1));
    compareValue("busy_acc_count", 192'(acc_log.size() - log_start), 192'(2));
    n_wr = 0;
    for (int k = log_start; k < acc_log.size(); k++) begin
      if (acc_log[k].we) n_wr++;
    end
    compareValue("busy_no_writes", 192'(n_wr), 192'(0));

    // Reset during a lock spin abandons the operation silently; a late
    // rvalid from the abandoned read arrives after release and is ignored.
    $display("[TB] sequence: reset during lock spin");
    configMem(0, 6, 1000);
    waitReady();
    req_from_core.header_data = '0;
    req_from_core.lsu_op      = LOCK;
    req_from_core.val         = 1'b1;
    @(negedge clk);
    req_from_core.val = 1'b0;
    repeat (12) @(negedge clk);
    rsp_before = rsp_count;
    rst = 1'b1;
    @(negedge clk);
    compareValue("spin_reset_mem_req", 192'(mem_req), 192'(0));
    compareValue("spin_reset_ready", 192'(lsu_ready), 192'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    compareValue("spin_release_ready", 192'(lsu_ready), 192'(1));
    repeat (8) @(negedge clk);
    compareValue("spin_no_rsp", 192'(rsp_count - rsp_before), 192'(0));
    compareValue("spin_idle_mem_req", 192'(mem_req), 192'(0));
    compareValue("spin_idle_ready", 192'(lsu_ready), 192'(1));
    applyStimulus(vecs[5]);
    checkOutput(vecs[5], 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/header_lsu.md
HEADER_LSU -- requirements
Module: header_lsu

Interface
REQ-001 Parameters SHALL be: LOCK_ADDR, 'h0, byte address of the allocator lock word; NEXT_OFFSET, DATA_W/8, byte offset of next_addr within a header (size at offset 0).
REQ-002 Ports SHALL be, clock and reset first: clk_i in 1, clock; rst_i in 1, reset; req_from_core_i in header_data_req_t, request {header_data, lsu_op, val}; lsu_ready_o out 1, request accept; rsp_to_core_o out header_data_rsp_t, response {header_data, val}; mem_req_o out 1; mem_we_o out 1; mem_addr_o out DATA_W; mem_wdata_o out DATA_W; mem_gnt_i in 1; mem_rvalid_i in 1; mem_rdata_i in DATA_W.
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-004 A request SHALL be accepted in any cycle where req_from_core_i.val and lsu_ready_o are both 1; header_data and lsu_op SHALL be latched in that cycle.
REQ-005 lsu_ready_o SHALL be 1 only in IDLE; exactly one request SHALL be in flight.
REQ-006 Each accepted request SHALL produce exactly one rsp_to_core_o.val pulse, one cycle wide, after its last memory access completes; lsu_ready_o SHALL return to 1 in the cycle after the pulse.
REQ-007 Memory handshake: mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o SHALL be held stable until mem_gnt_i; a write SHALL complete at gnt; a read SHALL complete on the first mem_rvalid_i after gnt (at least one cycle later); only one access SHALL be outstanding.
REQ-008 LOAD SHALL read size at addr, then next_addr at addr+NEXT_OFFSET; the response SHALL be {addr=latched addr, size, next_addr}.
REQ-009 INSERT SHALL write size to addr, then next_addr to addr+NEXT_OFFSET; the response SHALL echo the latched header_data.
REQ-010 DELETE SHALL write only next_addr to addr+NEXT_OFFSET, unlinking the removed node; the response SHALL echo the latched header_data.
REQ-011 LOCK SHALL read LOCK_ADDR; if the value is nonzero, it SHALL re-issue the read the next cycle (spin, no timeout); if zero, it SHALL write 1 to LOCK_ADDR, then respond with header_data='0.
REQ-012 UNLOCK SHALL write 0 to LOCK_ADDR, then respond with header_data='0; UNLOCK SHALL occur without a prior LOCK check.
REQ-013 An undefined lsu_op SHALL respond in the cycle after acceptance with header_data='0 and no memory access.
REQ-014 FSM states SHALL be: IDLE, RD_SIZE, RD_NEXT, WR_SIZE, WR_NEXT, LOCK_RD, LOCK_WR, UNLOCK_WR, RSP; each memory state SHALL cover both the request phase and the rvalid wait via a pending flag.
REQ-015 Address arithmetic SHALL be DATA_W-bit unsigned; addr+NEXT_OFFSET SHALL wrap modulo 2^DATA_W without error.
REQ-016 A request with val=1 that arrives while lsu_ready_o=0 SHALL be ignored, with no queueing.
REQ-017 mem_rvalid_i while no read is pending SHALL be ignored.

Reset
REQ-018 Under reset, state SHALL be IDLE, lsu_ready_o=0 during reset and 1 the cycle after, rsp_to_core_o='0, and mem_req_o=mem_we_o=0 with mem_addr_o=mem_wdata_o='0.
REQ-019 Reset mid-operation SHALL abandon the operation with no response; a late mem_rvalid_i after reset SHALL be ignored per REQ-017.

Structure
REQ-020 header_data_t, header_data_req_t, header_data_rsp_t, req_lsu_op_e (LOCK, UNLOCK, LOAD, INSERT, DELETE) and DATA_W SHALL come from allocator_pkg; the default LOCK_ADDR SHALL be defined there.
REQ-021 The FSM state enum SHALL be local to the module; the block SHALL have no sub-modules, and the single memory-port driver SHALL be inside the FSM.

Verification
REQ-022 LOAD addr='h10 with memory [0x10]=0x100 and [0x18]=0x40 (DATA_W=64) -> two reads at 0x10 and 0x18, then rsp {addr 0x10, size 0x100, next 0x40} pulsed once.
REQ-023 LOCK with [LOCK_ADDR]=1 for 3 reads, then 0 -> 4 reads and one write of 1, then one rsp; lsu_ready_o=0 throughout.
REQ-024 INSERT {0x90, 0xC0, 0x40} followed by DELETE {0x10, next 0x90} -> writes [0x90]=0xC0, [0x98]=0x40, [0x18]=0x90; one rsp per request.
REQ-025 mem_gnt_i stalled 5 cycles, then rvalid 3 cycles after gnt on a LOAD -> mem_* held stable; response correct and single.
REQ-026 rst_i asserted mid-LOCK spin -> mem_req_o=0 next cycle, no rsp, lsu_ready_o=1 after release; a subsequent UNLOCK writes 0 to LOCK_ADDR and responds.
